// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding and
// the default bound on consecutive data grants while a fetch waits.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned FAIR_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and data load/store, data first with a bounded fetch starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_mc_read,
  input  logic [ADDR_W-1:0] if_mc_addr,
  output logic [DATA_W-1:0] mc_if_data,
  output logic              mc_if_ready,
  input  logic              mem_mc_read,
  input  logic              mem_mc_write,
  input  logic [ADDR_W-1:0] mem_mc_addr,
  input  logic [DATA_W-1:0] mem_mc_wdata,
  output logic [DATA_W-1:0] mc_mem_rdata,
  output logic              mc_mem_ready,
  output logic              mc_ram_en,
  output logic              mc_ram_we,
  output logic [ADDR_W-1:0] mc_ram_addr,
  output logic [DATA_W-1:0] mc_ram_wdata,
  input  logic [DATA_W-1:0] ram_mc_rdata,
  input  logic              ram_mc_ack
);

  localparam int unsigned       CNT_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] fair_cnt;
  logic             data_pend;
  logic             fetch_pend;
  logic             data_wins;

  always_comb begin
    data_pend  = mem_mc_read | mem_mc_write;
    fetch_pend = if_mc_read;
    data_wins  = data_pend && (!fetch_pend || (fair_cnt < LIMIT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fair_cnt     <= '0;
      mc_if_data   <= '0;
      mc_if_ready  <= 1'b0;
      mc_mem_rdata <= '0;
      mc_mem_ready <= 1'b0;
      mc_ram_en    <= 1'b0;
      mc_ram_we    <= 1'b0;
      mc_ram_addr  <= '0;
      mc_ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_wins) begin
            state        <= DATA;
            mc_ram_en    <= 1'b1;
            // write wins when read and write are raised together
            mc_ram_we    <= mem_mc_write;
            mc_ram_addr  <= mem_mc_addr;
            mc_ram_wdata <= mem_mc_wdata;
            if (!fetch_pend)
              fair_cnt <= '0;
            else if (fair_cnt != LIMIT)
              fair_cnt <= fair_cnt + CNT_W'(1);
          end else if (fetch_pend) begin
            state       <= FETCH;
            mc_ram_en   <= 1'b1;
            mc_ram_we   <= 1'b0;
            mc_ram_addr <= if_mc_addr;
            fair_cnt    <= '0;
          end
        end

        FETCH: begin
          if (ram_mc_ack) begin
            state       <= DONE;
            mc_ram_en   <= 1'b0;
            mc_if_ready <= 1'b1;
            mc_if_data  <= ram_mc_rdata;
          end
        end

        DATA: begin
          if (ram_mc_ack) begin
            state        <= DONE;
            mc_ram_en    <= 1'b0;
            mc_mem_ready <= 1'b1;
            if (!mc_ram_we)
              mc_mem_rdata <= ram_mc_rdata;
          end
        end

        DONE: begin
          state        <= IDLE;
          mc_if_ready  <= 1'b0;
          mc_mem_ready <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and ready responses are
// queued by the stimulus and consumed by an independent negedge monitor.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    bit          chk_wdata;
  } grant_t;

  typedef struct {
    bit          fetch;
    logic [31:0] data;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_mc_read = 1'b0;
  logic [31:0] if_mc_addr = '0;
  logic [31:0] mc_if_data;
  logic        mc_if_ready;
  logic        mem_mc_read = 1'b0;
  logic        mem_mc_write = 1'b0;
  logic [31:0] mem_mc_addr = '0;
  logic [31:0] mem_mc_wdata = '0;
  logic [31:0] mc_mem_rdata;
  logic        mc_mem_ready;
  logic        mc_ram_en;
  logic        mc_ram_we;
  logic [31:0] mc_ram_addr;
  logic [31:0] mc_ram_wdata;
  logic [31:0] ram_mc_rdata;
  logic        ram_mc_ack;

  int     checks = 0;
  int     errors = 0;
  grant_t grant_q[$];
  resp_t  resp_q[$];

  bit          ram_auto   = 1'b1;
  bit          inject_ack = 1'b0;
  int          ram_lat    = 2;
  logic [31:0] last_load  = '0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_mc_read(if_mc_read), .if_mc_addr(if_mc_addr),
    .mc_if_data(mc_if_data), .mc_if_ready(mc_if_ready),
    .mem_mc_read(mem_mc_read), .mem_mc_write(mem_mc_write),
    .mem_mc_addr(mem_mc_addr), .mem_mc_wdata(mem_mc_wdata),
    .mc_mem_rdata(mc_mem_rdata), .mc_mem_ready(mc_mem_ready),
    .mc_ram_en(mc_ram_en), .mc_ram_we(mc_ram_we),
    .mc_ram_addr(mc_ram_addr), .mc_ram_wdata(mc_ram_wdata),
    .ram_mc_rdata(ram_mc_rdata), .ram_mc_ack(ram_mc_ack)
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    case (a)
      32'h0000_0040: img = 32'h2408_0005;
      32'h0000_0044: img = 32'h8C09_0010;
      32'h0000_0048: img = 32'h0109_5020;
      32'h0000_0080: img = 32'hA0A0_0080;
      32'h0000_0084: img = 32'hA0A0_0084;
      32'h0000_1000: img = 32'h1234_5678;
      32'h0000_1100: img = 32'h1100_0001;
      32'h0000_1104: img = 32'h1104_0002;
      32'h0000_1108: img = 32'h1108_0003;
      32'h0000_110C: img = 32'h110C_0004;
      32'h0000_1110: img = 32'h1110_0005;
      32'h0000_1114: img = 32'h1114_0006;
      default:       img = 32'hC0DE_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_grant(input logic [31:0] a, input logic we, input logic [31:0] wd);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd; g.chk_wdata = we;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input bit f, input logic [31:0] d);
    resp_t r;
    r.fetch = f; r.data = d;
    resp_q.push_back(r);
  endtask

  // Memory model: ack ram_lat negedges after en is seen, one cycle wide.
  initial begin
    int cnt = 0;
    ram_mc_ack   = 1'b0;
    ram_mc_rdata = '0;
    forever begin
      @(negedge clock);
      if (ram_mc_ack) begin
        ram_mc_ack = 1'b0;
      end else if (inject_ack) begin
        ram_mc_ack   = 1'b1;
        ram_mc_rdata = 32'hFFFF_0000;
      end else if (mc_ram_en && ram_auto) begin
        cnt++;
        if (cnt >= ram_lat) begin
          ram_mc_ack   = 1'b1;
          ram_mc_rdata = mc_ram_we ? 32'hBAD0_BAD0 : img(mc_ram_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: grants, held memory outputs, and ready pulses against the queues.
  initial begin
    grant_t cur;
    resp_t  r;
    bit     prev_en  = 1'b0;
    bit     prev_rdy = 1'b0;
    cur.addr = '0; cur.we = 1'b0; cur.wdata = '0; cur.chk_wdata = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_en  = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (mc_ram_en && !prev_en) begin
          if (grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant addr=%h required=none", mc_ram_addr);
          end else begin
            cur = grant_q.pop_front();
            chk("grant_addr", mc_ram_addr, cur.addr);
            chk("grant_we", 32'(mc_ram_we), 32'(cur.we));
            if (cur.chk_wdata) chk("grant_wdata", mc_ram_wdata, cur.wdata);
          end
        end else if (mc_ram_en) begin
          chk("hold_addr", mc_ram_addr, cur.addr);
          chk("hold_we", 32'(mc_ram_we), 32'(cur.we));
        end
        prev_en = mc_ram_en;

        if (mc_if_ready || mc_mem_ready) begin
          chk("ready_pulse_width", 32'(prev_rdy), 32'd0);
          chk("ready_exclusive", 32'(mc_if_ready & mc_mem_ready), 32'd0);
          if (resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready if=%b mem=%b required=none", mc_if_ready, mc_mem_ready);
          end else begin
            r = resp_q.pop_front();
            chk("ready_kind_fetch", 32'(mc_if_ready), 32'(r.fetch));
            if (r.fetch) chk("fetch_data", mc_if_data, r.data);
            else         chk("mem_rdata", mc_mem_rdata, r.data);
          end
        end
        prev_rdy = mc_if_ready | mc_mem_ready;
      end
    end
  end

  task automatic wait_ready(input bit fetch, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      seen = fetch ? mc_if_ready : mc_mem_ready;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout ready=0 required=1", tag);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    if_mc_read = 1'b1;
    if_mc_addr = a;
    wait_ready(1'b1, "fetch");
    if_mc_read = 1'b0;
  endtask

  task automatic do_data(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd);
    mem_mc_write = wr;
    mem_mc_read  = rd;
    mem_mc_addr  = a;
    mem_mc_wdata = wd;
    wait_ready(1'b0, "data");
    mem_mc_write = 1'b0;
    mem_mc_read  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_ram_en", 32'(mc_ram_en), 32'd0);
    chk("rst_if_ready", 32'(mc_if_ready), 32'd0);
    chk("rst_mem_ready", 32'(mc_mem_ready), 32'd0);
    chk("rst_ram_addr", mc_ram_addr, 32'd0);
    chk("rst_if_data", mc_if_data, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Fetch only, two-cycle memory latency
    ram_lat = 2;
    push_grant(32'h40, 1'b0, '0);
    push_resp(1'b1, img(32'h40));
    do_fetch(32'h40);

    // Simultaneous fetch and load: load first
    ram_lat = 1;
    push_grant(32'h1000, 1'b0, '0);
    push_grant(32'h44, 1'b0, '0);
    push_resp(1'b0, img(32'h1000));
    push_resp(1'b1, img(32'h44));
    last_load = img(32'h1000);
    fork
      do_fetch(32'h44);
      do_data(1'b0, 1'b1, 32'h1000, '0);
    join

    // Store with read and write both high
    push_grant(32'h2000, 1'b1, 32'hDEAD_BEEF);
    push_resp(1'b0, last_load);
    do_data(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF);
    chk("store_rdata_held", mc_mem_rdata, last_load);

    // Fairness: four data grants, one fetch, then data resumes
    for (int i = 0; i < 4; i++) push_grant(32'h1100 + 32'(4 * i), 1'b0, '0);
    push_grant(32'h48, 1'b0, '0);
    push_grant(32'h1110, 1'b0, '0);
    push_grant(32'h1114, 1'b0, '0);
    for (int i = 0; i < 4; i++) push_resp(1'b0, img(32'h1100 + 32'(4 * i)));
    push_resp(1'b1, img(32'h48));
    push_resp(1'b0, img(32'h1110));
    push_resp(1'b0, img(32'h1114));
    last_load = img(32'h1114);
    fork
      do_fetch(32'h48);
      begin
        mem_mc_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
          mem_mc_addr = 32'h1100 + 32'(4 * i);
          wait_ready(1'b0, "fair_data");
        end
        mem_mc_read = 1'b0;
      end
    join

    // Held request through DONE, new request the following cycle
    push_grant(32'h80, 1'b0, '0);
    push_grant(32'h84, 1'b0, '0);
    push_resp(1'b1, img(32'h80));
    push_resp(1'b1, img(32'h84));
    do_fetch(32'h80);
    if_mc_read = 1'b1;
    if_mc_addr = 32'h84;
    @(posedge clock); #1;
    chk("regrant_en", 32'(mc_ram_en), 32'd1);
    chk("regrant_addr", mc_ram_addr, 32'h84);
    wait_ready(1'b1, "regrant");
    if_mc_read = 1'b0;

    // Reset while a load awaits ack, then a late ack
    ram_auto = 1'b0;
    push_grant(32'h3000, 1'b0, '0);
    mem_mc_read = 1'b1;
    mem_mc_addr = 32'h3000;
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_en", 32'(mc_ram_en), 32'd0);
    chk("async_rst_addr", mc_ram_addr, 32'd0);
    chk("async_rst_mem_rdata", mc_mem_rdata, 32'd0);
    mem_mc_read = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    inject_ack = 1'b1;
    @(posedge clock); #1 inject_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("late_ack_en", 32'(mc_ram_en), 32'd0);
      chk("late_ack_mem_ready", 32'(mc_mem_ready), 32'd0);
    end
    @(posedge clock); #1;
    ram_auto = 1'b1;
    ram_lat  = 2;
    push_grant(32'h40, 1'b0, '0);
    push_resp(1'b1, img(32'h40));
    if_mc_read = 1'b1;
    if_mc_addr = 32'h40;
    @(posedge clock); #1;
    chk("post_rst_idle_grant", 32'(mc_ram_en), 32'd1);
    wait_ready(1'b1, "post_rst");
    if_mc_read = 1'b0;

    repeat (5) @(negedge clock);
    chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
